dma_reg_arbiter: RTL and testbench

Parametrised multi-master front end for the DMA register bus (wr_en/rd_en/addr/wdata/rdata). It arbitrates NUM_MASTERS independent requesters (CPU port, debug port, per-channel descriptor fetchers) onto the single register-bus port using round-robin arbitration. It supports pipelined reads with fixed slave read latency and returns read data to the originating master, tagged by master ID.

---
 rtl/dma_reg_arbiter.sv | 117 +++++++++++
 tb/tb_dma_reg_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_reg_arbiter.sv
// Round-robin front end that funnels NUM_MASTERS requesters onto one register bus
// and routes pipelined read data back to the issuing master by ID.
module dma_reg_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int RD_LATENCY  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          wr_en,
  output logic                          rd_en,
  output logic [ADDR_W-1:0]             addr,
  output logic [DATA_W-1:0]             wdata,
  input  logic [DATA_W-1:0]             rdata,
  output logic                          busy
);

  localparam int ID_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int STAGES = RD_LATENCY + 1;

  function automatic logic [NUM_MASTERS-1:0] id_onehot(input logic [ID_W-1:0] id);
    id_onehot     = '0;
    id_onehot[id] = 1'b1;
  endfunction

  logic [ID_W-1:0]   ptr;
  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   cand;
  int                idx;
  logic              rd_issue;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [STAGES-1:0] tag_vld_p;
  logic [ID_W-1:0]   tag_id_p [STAGES];

  // Arbitration: first requester strictly after the last winner, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx  = (int'(ptr) + k) % NUM_MASTERS;
      cand = ID_W'(idx);
      if (!gnt_vld && m_req[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign m_gnt     = gnt_vld ? id_onehot(gnt_id) : '0;
  assign rd_issue  = gnt_vld && !m_we[gnt_id];
  assign sel_addr  = m_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
  assign sel_wdata = m_wdata[int'(gnt_id)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= ID_W'(NUM_MASTERS - 1);
    end else if (gnt_vld) begin
      ptr <= gnt_id;
    end
  end

  // Stage p0: registered bus command, one cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      wr_en <= gnt_vld && m_we[gnt_id];
      rd_en <= rd_issue;
      if (gnt_vld) begin
        addr  <= sel_addr;
        wdata <= m_we[gnt_id] ? sel_wdata : '0;
      end
    end
  end

  // Tag stages: stage 0 lines up with rd_en, last stage with valid slave rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_p <= '0;
      for (int s = 0; s < STAGES; s++) tag_id_p[s] <= '0;
    end else begin
      tag_vld_p   <= {tag_vld_p[STAGES-2:0], rd_issue};
      tag_id_p[0] <= gnt_id;
      for (int s = 1; s < STAGES; s++) tag_id_p[s] <= tag_id_p[s-1];
    end
  end

  assign busy = |tag_vld_p;

  // Return stage: capture slave data and pulse the owner's rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rvalid <= '0;
      m_rdata  <= '0;
    end else begin
      m_rvalid <= tag_vld_p[STAGES-1] ? id_onehot(tag_id_p[STAGES-1]) : '0;
      if (tag_vld_p[STAGES-1]) m_rdata <= rdata;
    end
  end

endmodule

// File: tb/tb_dma_reg_arbiter.sv
// Directed bench for dma_reg_arbiter with a one-cycle-latency register slave.
module tb_dma_reg_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_gnt;
  logic [N-1:0]    m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic            wr_en;
  logic            rd_en;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata = '0;
  logic            busy;

  int vectors     = 0;
  int miscompares = 0;

  dma_reg_arbiter #(.NUM_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Slave: written locations remember data, unwritten ones return fixed contents.
  logic [DW-1:0] mem [0:255];
  logic [255:0]  wrt = '0;

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    case (a)
      32'h20:  rom = 32'hCAFE0001;
      32'h30:  rom = 32'h11;
      32'h34:  rom = 32'h33;
      default: rom = '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (wr_en) begin
      mem[addr[7:0]] <= wdata;
      wrt[addr[7:0]] <= 1'b1;
    end
    if (rd_en) rdata <= wrt[addr[7:0]] ? mem[addr[7:0]] : rom(addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    m_we[i]            = we;
    m_addr[i*AW +: AW] = a;
    m_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    rst_n   = 1'b0;
    m_req   = '0;
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;
    tick();
    tick();
    #1;
    check("rst_wr_en",  64'(wr_en),    64'h0);
    check("rst_rd_en",  64'(rd_en),    64'h0);
    check("rst_addr",   64'(addr),     64'h0);
    check("rst_wdata",  64'(wdata),    64'h0);
    check("rst_rvalid", 64'(m_rvalid), 64'h0);
    check("rst_rdata",  64'(m_rdata),  64'h0);
    check("rst_busy",   64'(busy),     64'h0);
    check("rst_gnt",    64'(m_gnt),    64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single write from master 2
    set_master(2, 1'b1, 32'h10, 32'hDEADBEEF);
    m_req = 4'b0100;
    #1 check("w_gnt", 64'(m_gnt), 64'b0100);
    tick();
    m_req = '0;
    #1;
    check("w_wr_en", 64'(wr_en), 64'h1);
    check("w_rd_en", 64'(rd_en), 64'h0);
    check("w_addr",  64'(addr),  64'h10);
    check("w_wdata", 64'(wdata), 64'hDEADBEEF);
    check("w_gnt0",  64'(m_gnt), 64'h0);
    tick();
    #1;
    check("w_wr_off",  64'(wr_en), 64'h0);
    check("w_addr_hold", 64'(addr), 64'h10);

    // Read return from master 1 (pointer at 2, so 3,0,1 searched)
    set_master(1, 1'b0, 32'h20, 32'h0);
    m_req = 4'b0010;
    #1;
    check("r_gnt",   64'(m_gnt), 64'b0010);
    check("r_busy0", 64'(busy),  64'h0);
    tick();
    m_req = '0;
    #1;
    check("r_rd_en",  64'(rd_en),    64'h1);
    check("r_wr_en",  64'(wr_en),    64'h0);
    check("r_addr",   64'(addr),     64'h20);
    check("r_wdata",  64'(wdata),    64'h0);
    check("r_busy1",  64'(busy),     64'h1);
    check("r_rv1",    64'(m_rvalid), 64'h0);
    tick();
    #1;
    check("r_busy2",  64'(busy),     64'h1);
    check("r_rd_off", 64'(rd_en),    64'h0);
    check("r_rv2",    64'(m_rvalid), 64'h0);
    tick();
    #1;
    check("r_rv3",    64'(m_rvalid), 64'b0010);
    check("r_rdata",  64'(m_rdata),  64'hCAFE0001);
    check("r_busy3",  64'(busy),     64'h0);
    tick();
    #1 check("r_rv4", 64'(m_rvalid), 64'h0);

    // Round-robin with all masters requesting from reset
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_master(i, 1'b1, 32'h90 + 32'(4*i), 32'hA0 + 32'(i));
    m_req = 4'b1111;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr_gnt%0d", k), 64'(m_gnt), 64'(4'b0001 << (k % 4)));
      if (k > 0) begin
        check($sformatf("rr_wr%0d", k),   64'(wr_en), 64'h1);
        check($sformatf("rr_addr%0d", k), 64'(addr),  64'(32'h90 + 32'(4*((k-1) % 4))));
      end
      tick();
    end
    m_req = '0;
    tick();

    // Pipelined reads from masters 0 then 3 (pointer at 3)
    set_master(0, 1'b0, 32'h30, 32'h0);
    set_master(3, 1'b0, 32'h34, 32'h0);
    m_req = 4'b0001;
    #1 check("p_gnt0", 64'(m_gnt), 64'b0001);
    tick();
    m_req = 4'b1000;
    #1;
    check("p_gnt3",  64'(m_gnt), 64'b1000);
    check("p_rd0",   64'(rd_en), 64'h1);
    check("p_addr0", 64'(addr),  64'h30);
    tick();
    m_req = '0;
    #1;
    check("p_rd3",   64'(rd_en), 64'h1);
    check("p_addr3", 64'(addr),  64'h34);
    tick();
    #1;
    check("p_rv0",   64'(m_rvalid), 64'b0001);
    check("p_data0", 64'(m_rdata),  64'h11);
    tick();
    #1;
    check("p_rv3",   64'(m_rvalid), 64'b1000);
    check("p_data3", 64'(m_rdata),  64'h33);
    tick();
    #1;
    check("p_rv_off", 64'(m_rvalid), 64'h0);
    check("p_busy",   64'(busy),     64'h0);

    // Write then read of the same address (pointer at 3)
    set_master(0, 1'b1, 32'h40, 32'h55);
    set_master(1, 1'b0, 32'h40, 32'h0);
    m_req = 4'b0011;
    #1 check("o_gnt0", 64'(m_gnt), 64'b0001);
    tick();
    m_req = 4'b0010;
    #1;
    check("o_gnt1",  64'(m_gnt), 64'b0010);
    check("o_wr",    64'(wr_en), 64'h1);
    check("o_waddr", 64'(addr),  64'h40);
    check("o_wdata", 64'(wdata), 64'h55);
    tick();
    m_req = '0;
    #1;
    check("o_rd",    64'(rd_en), 64'h1);
    check("o_wr0",   64'(wr_en), 64'h0);
    check("o_raddr", 64'(addr),  64'h40);
    tick();
    tick();
    #1;
    check("o_rv",    64'(m_rvalid), 64'b0010);
    check("o_rdata", 64'(m_rdata),  64'h55);

    // Reset while a read from master 2 is in flight (pointer at 1)
    tick();
    set_master(2, 1'b0, 32'h20, 32'h0);
    m_req = 4'b0100;
    #1 check("x_gnt", 64'(m_gnt), 64'b0100);
    tick();
    m_req = '0;
    #1;
    check("x_rd",   64'(rd_en), 64'h1);
    check("x_busy", 64'(busy),  64'h1);
    rst_n = 1'b0;
    #1;
    check("x_rd_async",   64'(rd_en), 64'h0);
    check("x_busy_async", 64'(busy),  64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1 check($sformatf("x_rv_rst%0d", k), 64'(m_rvalid), 64'h0);
    end
    tick();
    rst_n = 1'b1;
    set_master(0, 1'b1, 32'h50, 32'h1);
    set_master(3, 1'b1, 32'h54, 32'h3);
    m_req = 4'b1001;
    #1 check("x_first_gnt", 64'(m_gnt), 64'b0001);
    tick();
    m_req = '0;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("x_rv_post%0d", k), 64'(m_rvalid), 64'h0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
